// File: rtl/rv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_responder
// Brief    : RAM + MMIO responder for the RV core instruction/data buses.
//            Optional debug console FIFO is built when DEBUG_CONSOLE_EN is defined.
// Revision : 1.0
// ============================================================================
module rv_mem_responder #(
  parameter int MEM_WORDS  = 16384,
  parameter int CONS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  output logic [31:0] instruction,
  input  logic        read,
  input  logic [31:0] read_address,
  output logic [31:0] data_rd,
  input  logic [3:0]  write,
  input  logic [31:0] write_address,
  input  logic [31:0] data_wr,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        halt
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(CONS_DEPTH);

  localparam logic [2:0] OFF_CONS_DATA = 3'd0;
  localparam logic [2:0] OFF_CONS_STAT = 3'd1;
  localparam logic [2:0] OFF_CYCLE_LO  = 3'd2;
  localparam logic [2:0] OFF_CYCLE_HI  = 3'd3;
  localparam logic [2:0] OFF_HALT      = 3'd4;

  logic [31:0]   mem [MEM_WORDS];
  logic [63:0]   cycle;
  logic [31:0]   cons_stat;
  logic [31:0]   mmio_rdata;
  logic          cons_push_req;

  logic [AW-1:0] i_idx;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx;
  logic          store_ram;
  logic          store_mmio;

  assign i_idx      = i_address[AW+1:2];
  assign r_idx      = read_address[AW+1:2];
  assign w_idx      = write_address[AW+1:2];
  assign store_ram  = (write != 4'b0000) && !write_address[31];
  assign store_mmio = (write != 4'b0000) &&  write_address[31];

  assign cons_push_req = store_mmio && write[0] && (write_address[4:2] == OFF_CONS_DATA);

  // Unused address bits (offset, aliased upper bits) are intentionally ignored.
  logic unused_addr;
  assign unused_addr = &{1'b0, i_address, read_address, write_address};

  // Nonblocking update gives read-before-write on same-word collisions.
  always_ff @(posedge clk) begin
    if (!reset && store_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (write[b]) begin
          mem[w_idx][8*b +: 8] <= data_wr[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    mmio_rdata = 32'h0;
    case (read_address[4:2])
      OFF_CONS_STAT: mmio_rdata = cons_stat;
      OFF_CYCLE_LO:  mmio_rdata = cycle[31:0];
      OFF_CYCLE_HI:  mmio_rdata = cycle[63:32];
      OFF_HALT:      mmio_rdata = {31'b0, halt};
      default:       mmio_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= 32'h0;
      data_rd     <= 32'h0;
    end else begin
      instruction <= i_address[31] ? 32'h0 : mem[i_idx];
      if (read) begin
        data_rd <= read_address[31] ? mmio_rdata : mem[r_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= 64'h0;
      halt  <= 1'b0;
    end else begin
      cycle <= cycle + 64'd1;
      if (store_mmio && (write_address[4:2] == OFF_HALT)) begin
        halt <= 1'b1;
      end
    end
  end

`ifdef DEBUG_CONSOLE_EN
  logic [7:0]    fifo [CONS_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;

  assign full    = (count == (PW+1)'(CONS_DEPTH));
  assign empty   = (count == '0);
  assign pop     = !empty && tx_ready;
  // A pop on the same edge frees the slot the push lands in.
  assign push_ok = cons_push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      fifo[wr_ptr] <= data_wr[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (cons_push_req && full && !pop) begin
        overflow <= 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    cons_stat             = 32'h0;
    cons_stat[0]          = full;
    cons_stat[1]          = empty;
    cons_stat[2]          = overflow;
    cons_stat[8 +: PW+1]  = count;
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo[rd_ptr];
`else
  logic unused_console;
  assign unused_console = &{1'b0, tx_ready, cons_push_req};
  assign cons_stat      = 32'h0;
  assign tx_valid       = 1'b0;
  assign tx_data        = 8'h00;
`endif

endmodule
`default_nettype wire

// File: doc/rv_mem_responder.md
# rv_mem_responder

Memory-side responder for the RV core's instruction and data buses. It serves instruction fetches and data loads from an internal word-addressed RAM with one-cycle registered latency. It applies byte-enabled stores. It also decodes a small MMIO window holding a debug console TX FIFO, a 64-bit cycle counter and a halt register. It sits directly opposite the core top, one instance per core, in simulation and FPGA builds.

## Interface
Parameters:
- `MEM_WORDS`, 16384 — RAM depth in 32-bit words; power of two.
- `CONS_DEPTH`, 4 — console FIFO depth in bytes; power of two, ≥2.

Ports:
- `clk`  in  1 — single clock; all state updates on its rising edge.
- `reset`  in  1 — synchronous, active-high.
- `i_address`  in  32 — instruction fetch address.
- `instruction`  out  32 — fetched word, registered.
- `read`  in  1 — data load enable.
- `read_address`  in  32 — data load address.
- `data_rd`  out  32 — load data, registered.
- `write`  in  4 — store byte enables; bit n selects bits [8n+7:8n].
- `write_address`  in  32 — store address.
- `data_wr`  in  32 — store data.
- `tx_valid`  out  1 — console byte available.
- `tx_ready`  in  1 — console sink accepts byte.
- `tx_data`  out  8 — console byte, FIFO head.
- `halt`  out  1 — sticky end-of-program flag.

## Operation
- **Address decode:**
  - addr[31]=0 selects RAM, word index addr[$clog2(MEM_WORDS)+1:2]; upper bits ignored, so RAM aliases.
  - addr[1:0] is ignored everywhere.
  - addr[31]=1 selects MMIO; only addr[4:2] is decoded.
- **MMIO map:**
  - 0x8000_0000 CONS_DATA: write with write[0]=1 pushes data_wr[7:0]; write[0]=0 is ignored. Reads 0.
  - 0x8000_0004 CONS_STAT: read-only. Bit0 = full, bit1 = empty, bit2 = overflow (sticky), bits[15:8] = count.
  - 0x8000_0008 CYCLE_LO and 0x8000_000C CYCLE_HI: read-only halves of the free-running 64-bit counter. It increments every cycle and wraps to 0.
  - 0x8000_0010 HALT: a write with any write bit set sets `halt`=1. `halt` stays 1 until reset. Reads return {31'b0, halt}.
  - Other MMIO offsets read 0; writes to them are ignored.
- **Instruction port:**
  - Every cycle, `instruction` <= RAM[i_address].
  - An MMIO i_address yields 0.
- **Data loads:**
  - When read=1, `data_rd` <= selected RAM word or MMIO value.
  - When read=0, `data_rd` holds its value.
- **Data stores:**
  - When write≠0 to RAM, only the enabled bytes of the word are updated.
  - When write≠0 to MMIO, the MMIO rules above apply.
- **Same-edge collisions (read-before-write):**
  - A load or fetch hitting the word being stored in the same cycle returns the old contents.
  - Load and store to different addresses in the same cycle are both serviced.
- **Console FIFO:**
  - `tx_valid`=!empty and `tx_data`=head.
  - A pop occurs when tx_valid && tx_ready.
  - A push to a full FIFO is dropped and sets overflow, unless a pop happens on the same edge; in that case the push is accepted and count is unchanged.
  - A push and a pop together on a non-full, non-empty FIFO leave count unchanged.
  - A push to an empty FIFO is visible on `tx_valid` the next cycle; there is no bypass.
  - Read/write pointers are log2(CONS_DEPTH) bits and wrap. count is log2(CONS_DEPTH)+1 bits.

## Timing
- **Reset values** (synchronous reset, takes effect on the edge):
  - `instruction`=0, `data_rd`=0, `tx_valid`=0, `tx_data`=0, `halt`=0.
  - Cycle counter=0; FIFO empty; overflow=0.
  - RAM contents are not reset.
- **Reset mid-operation:** any store on the reset edge is not applied. Queued console bytes are discarded.
- **Latency:**
  - Fetch and load: address sampled at edge N, data valid after edge N, stable through cycle N+1.
  - Store: memory updated at edge N.
- **CYCLE_LO/CYCLE_HI reads:**
  - Each returns the counter value held before edge N. The first cycle after reset reads 0.
  - Reading LO then HI is not atomic; software handles carry.
- **CONS_STAT:** reflects state before the edge; it does not include a push or pop on the same edge.
- **tx handshake:** `tx_data` must not change while tx_valid=1 and tx_ready=0.

## Configuration
- `DEBUG_CONSOLE_EN` defined: console FIFO, CONS_DATA and CONS_STAT are implemented as above.
- Not defined:
  - No FIFO storage is built; `tx_valid`=0 and `tx_data`=0 constantly.
  - CONS_DATA writes are ignored and CONS_STAT reads 0.
  - RAM, the cycle counter and HALT are unaffected.

## Test plan
- **Byte-enable store:** store 0xAABBCCDD to 0x100 with write=4'b1111, then store 0x11223344 with write=4'b0101 -> load of 0x100 one cycle later returns 0xAA22CC44. A fetch at 0x100 returns the same value.
- **Collision:** on one edge, load 0x200 (old value 0x12345678) and store 0xFFFFFFFF to 0x200 -> `data_rd`=0x12345678. The next load returns 0xFFFFFFFF. `data_rd` holds while read=0.
- **Console fill and overflow (CONS_DEPTH=4, tx_ready=0):**
  - Push 0x41..0x45 -> CONS_STAT reads 0x0000_0405 (count 4, full, overflow).
  - Raise tx_ready -> bytes 0x41,0x42,0x43,0x44 are emitted in order, then tx_valid=0. Overflow stays set.
- **Full FIFO with simultaneous push and pop:** push 0x55 while tx_ready=1 -> push accepted, count stays 4. 0x55 emerges fourth after the current head.
- **Counter and halt:**
  - After reset release, read CYCLE_LO at the 10th edge -> 9.
  - Preload counter to 0xFFFFFFFF in LO via force -> HI increments on wrap.
  - Write HALT with write=4'b0001 -> `halt`=1 after that edge. Assert reset -> `halt`=0, `tx_valid`=0, counter 0.
- **Build without DEBUG_CONSOLE_EN:** push 0x41 -> `tx_valid` stays 0 and CONS_STAT reads 0. RAM and HALT behave identically.
